// File: rtl/sargantana_icache_pkg.sv
// Shared types and sizing for the instruction-cache refill path.
// Default geometry: 4 ways, 256-bit lines, 64-bit memory beats.
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY = 4;
  localparam int TAG_WIDHT    = 20;
  localparam int IDX_WIDTH    = 6;
  localparam int WAY_WIDHT    = 256;
  localparam int BEAT_WIDTH   = 64;

  localparam int N_BEATS   = WAY_WIDHT / BEAT_WIDTH;
  localparam int CNT_W     = $clog2(N_BEATS);
  localparam int WAY_IDX_W = $clog2(ICACHE_N_WAY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_COLLECT,
    S_WRITE
  } ifill_state_t;

  typedef struct packed {
    logic [TAG_WIDHT-1:0] tag;
    logic [IDX_WIDTH-1:0] idx;
  } req_addr_t;

endpackage

// File: rtl/sargantana_icache_victim_sel.sv
// Victim way picker: lowest invalid way, else the round-robin pointer.
// Purely combinational; the pointer register lives in the caller.
module sargantana_icache_victim_sel #(
  parameter int N_WAY = 4,
  parameter int PW    = $clog2(N_WAY)
) (
  input  logic [N_WAY-1:0] valid_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_WAY-1:0] way_o,
  output logic             all_valid_o
);

  logic [PW-1:0] sel;

  always_comb begin
    all_valid_o = &valid_i;
    sel         = ptr_i;
    // Walk downwards so the lowest invalid way is the last to win.
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (!valid_i[i]) sel = PW'(i);
    end
    way_o      = '0;
    way_o[sel] = 1'b1;
  end

endmodule

// File: rtl/sargantana_icache_ifill.sv
// I-cache refill: one line request, beat assembly, victim pick and
// a single-cycle tag/data array write.
module sargantana_icache_ifill
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY = sargantana_icache_pkg::ICACHE_N_WAY,
  parameter int TAG_WIDHT    = sargantana_icache_pkg::TAG_WIDHT,
  parameter int IDX_WIDTH    = sargantana_icache_pkg::IDX_WIDTH,
  parameter int WAY_WIDHT    = sargantana_icache_pkg::WAY_WIDHT,
  parameter int BEAT_WIDTH   = sargantana_icache_pkg::BEAT_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          miss_i,
  input  logic [TAG_WIDHT-1:0]          miss_tag_i,
  input  logic [IDX_WIDTH-1:0]          miss_idx_i,
  input  logic [ICACHE_N_WAY-1:0]       way_valid_bits_i,
  input  logic                          flush_i,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [TAG_WIDHT+IDX_WIDTH-1:0] mem_req_addr_o,
  input  logic                          mem_rsp_valid_i,
  input  logic [BEAT_WIDTH-1:0]         mem_rsp_data_i,
  input  logic                          mem_rsp_error_i,
  output logic [WAY_WIDHT-1:0]          ifill_data_o,
  output logic                          fill_we_o,
  output logic [ICACHE_N_WAY-1:0]       fill_way_o,
  output logic [TAG_WIDHT-1:0]          fill_tag_o,
  output logic [IDX_WIDTH-1:0]          fill_idx_o,
  output logic                          busy_o,
  output logic                          fill_error_o
);

  localparam int NB = WAY_WIDHT / BEAT_WIDTH;
  localparam int CW = $clog2(NB);
  localparam int PW = $clog2(ICACHE_N_WAY);

  ifill_state_t state_q, state_d;

  logic [TAG_WIDHT-1:0]    tag_q, tag_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [ICACHE_N_WAY-1:0] way_q, way_d;
  logic                    use_rr_q, use_rr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    kill_q, kill_d;
  logic [WAY_WIDHT-1:0]    line_q, line_d;
  logic [PW-1:0]           rr_q, rr_d;
  logic                    ferr_q, ferr_d;

  logic [ICACHE_N_WAY-1:0] vic_way;
  logic                    vic_all_valid;
  req_addr_t               req_addr;

  sargantana_icache_victim_sel #(
    .N_WAY (ICACHE_N_WAY),
    .PW    (PW)
  ) u_victim_sel (
    .valid_i     (way_valid_bits_i),
    .ptr_i       (rr_q),
    .way_o       (vic_way),
    .all_valid_o (vic_all_valid)
  );

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    idx_d    = idx_q;
    way_d    = way_q;
    use_rr_d = use_rr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    kill_d   = kill_q;
    line_d   = line_q;
    rr_d     = rr_q;
    ferr_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (miss_i) begin
          tag_d    = miss_tag_i;
          idx_d    = miss_idx_i;
          way_d    = vic_way;
          use_rr_d = vic_all_valid;
          cnt_d    = '0;
          err_d    = 1'b0;
          kill_d   = 1'b0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready_i) begin
          kill_d  = flush_i;
          state_d = S_COLLECT;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (flush_i) kill_d = 1'b1;
        if (mem_rsp_valid_i) begin
          line_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = mem_rsp_data_i;
          cnt_d = cnt_q + CW'(1);
          if (mem_rsp_error_i) err_d = 1'b1;
          if (cnt_q == CW'(NB - 1)) begin
            if (err_q || mem_rsp_error_i) begin
              ferr_d  = 1'b1;
              state_d = S_IDLE;
            end else if (kill_q || flush_i) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        // Filling an invalid way leaves the replacement order alone.
        if (!flush_i && use_rr_q) rr_d = rr_q + PW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      tag_q    <= '0;
      idx_q    <= '0;
      way_q    <= '0;
      use_rr_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      kill_q   <= 1'b0;
      line_q   <= '0;
      rr_q     <= '0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      way_q    <= way_d;
      use_rr_q <= use_rr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      kill_q   <= kill_d;
      line_q   <= line_d;
      rr_q     <= rr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign req_addr.tag    = tag_q;
  assign req_addr.idx    = idx_q;
  assign mem_req_addr_o  = req_addr;
  assign mem_req_valid_o = (state_q == S_REQ);
  assign busy_o          = (state_q != S_IDLE);
  assign fill_we_o       = (state_q == S_WRITE) && !flush_i;
  assign ifill_data_o    = line_q;
  assign fill_way_o      = way_q;
  assign fill_tag_o      = tag_q;
  assign fill_idx_o      = idx_q;
  assign fill_error_o    = ferr_q;

endmodule

// File: tb/tb_sargantana_icache_ifill.sv
// Scoreboard bench for the I-cache refill unit: directed refills push
// expected writes/error pulses; a negedge monitor pops and compares.
module tb_sargantana_icache_ifill;

  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic         miss_i = 1'b0;
  logic [19:0]  miss_tag_i = '0;
  logic [5:0]   miss_idx_i = '0;
  logic [3:0]   way_valid_bits_i = '0;
  logic         flush_i = 1'b0;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i = 1'b0;
  logic [25:0]  mem_req_addr_o;
  logic         mem_rsp_valid_i = 1'b0;
  logic [63:0]  mem_rsp_data_i = '0;
  logic         mem_rsp_error_i = 1'b0;
  logic [255:0] ifill_data_o;
  logic         fill_we_o;
  logic [3:0]   fill_way_o;
  logic [19:0]  fill_tag_o;
  logic [5:0]   fill_idx_o;
  logic         busy_o;
  logic         fill_error_o;

  sargantana_icache_ifill dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .miss_i           (miss_i),
    .miss_tag_i       (miss_tag_i),
    .miss_idx_i       (miss_idx_i),
    .way_valid_bits_i (way_valid_bits_i),
    .flush_i          (flush_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_rsp_valid_i  (mem_rsp_valid_i),
    .mem_rsp_data_i   (mem_rsp_data_i),
    .mem_rsp_error_i  (mem_rsp_error_i),
    .ifill_data_o     (ifill_data_o),
    .fill_we_o        (fill_we_o),
    .fill_way_o       (fill_way_o),
    .fill_tag_o       (fill_tag_o),
    .fill_idx_o       (fill_idx_o),
    .busy_o           (busy_o),
    .fill_error_o     (fill_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit           is_err;
    logic [255:0] data;
    logic [3:0]   way;
    logic [19:0]  tag;
    logic [5:0]   idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rr = 0;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat(input logic [7:0] seed, input int k);
    logic [7:0] b;
    b = seed * 8'(k + 1);
    return {8{b}};
  endfunction

  always @(negedge clk_i) begin
    if (rstn_i && (fill_we_o || fill_error_o)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out we=%0b err=%0b expected none",
                 fill_we_o, fill_error_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_err) begin
          chk("err_pulse", {fill_error_o, fill_we_o}, 2'b10);
        end else begin
          chk("we_only", {fill_we_o, fill_error_o}, 2'b10);
          chk("fill_data", ifill_data_o, e.data);
          chk("fill_way", fill_way_o, e.way);
          chk("fill_tag", fill_tag_o, e.tag);
          chk("fill_idx", fill_idx_o, e.idx);
        end
      end
    end
  end

  task automatic refill(input logic [19:0] tag, input logic [5:0] idx,
                        input logic [3:0] vb, input logic [7:0] seed,
                        input int stall, input int err_beat,
                        input int flush_beat);
    exp_t e;
    logic [3:0] way;
    bit use_rr;
    use_rr = (vb == 4'hF);
    way = 4'h0;
    if (use_rr) way[rr] = 1'b1;
    else begin
      for (int i = 3; i >= 0; i--) if (!vb[i]) way = 4'(1 << i);
    end
    e.is_err = (err_beat >= 0);
    e.data = {beat(seed, 3), beat(seed, 2), beat(seed, 1), beat(seed, 0)};
    e.way = way;
    e.tag = tag;
    e.idx = idx;
    if (err_beat >= 0) exp_q.push_back(e);
    else if (flush_beat < 0) begin
      exp_q.push_back(e);
      if (use_rr) rr = (rr + 1) % 4;
    end
    @(negedge clk_i);
    miss_i = 1'b1;
    miss_tag_i = tag;
    miss_idx_i = idx;
    way_valid_bits_i = vb;
    @(negedge clk_i);
    miss_i = 1'b0;
    chk("req_valid", mem_req_valid_o, 1'b1);
    chk("req_addr", mem_req_addr_o, {tag, idx});
    repeat (stall) begin
      @(negedge clk_i);
      chk("req_valid_stall", mem_req_valid_o, 1'b1);
      chk("req_addr_stall", mem_req_addr_o, {tag, idx});
    end
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      mem_rsp_data_i = beat(seed, k);
      mem_rsp_error_i = (k == err_beat);
      flush_i = (k == flush_beat);
    end
    @(negedge clk_i);
    mem_rsp_valid_i = 1'b0;
    mem_rsp_error_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("busy_after", busy_o, 1'b0);
  endtask

  task automatic req_flush(input logic [19:0] tag, input logic [5:0] idx);
    @(negedge clk_i);
    miss_i = 1'b1;
    miss_tag_i = tag;
    miss_idx_i = idx;
    way_valid_bits_i = 4'hF;
    @(negedge clk_i);
    miss_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("rf_valid", mem_req_valid_o, 1'b1);
      chk("rf_addr", mem_req_addr_o, {tag, idx});
      if (c == 3) flush_i = 1'b1;
      @(negedge clk_i);
    end
    flush_i = 1'b0;
    chk("rf_busy_fall", busy_o, 1'b0);
    chk("rf_req_drop", mem_req_valid_o, 1'b0);
  endtask

  task automatic all_zero(input string tag_s);
    chk({tag_s, "_busy"}, busy_o, 1'b0);
    chk({tag_s, "_reqv"}, mem_req_valid_o, 1'b0);
    chk({tag_s, "_addr"}, mem_req_addr_o, '0);
    chk({tag_s, "_we"}, fill_we_o, 1'b0);
    chk({tag_s, "_way"}, fill_way_o, '0);
    chk({tag_s, "_data"}, ifill_data_o, '0);
    chk({tag_s, "_err"}, fill_error_o, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    all_zero("rst");
    rstn_i = 1'b1;

    refill(20'hABCDE, 6'h05, 4'hF, 8'h11, 0, -1, -1);
    refill(20'h12345, 6'h2A, 4'b1011, 8'h5A, 0, -1, -1);
    refill(20'h0F0F0, 6'h3F, 4'hF, 8'h21, 5, -1, -1);
    req_flush(20'h55555, 6'h11);
    refill(20'h00001, 6'h01, 4'hF, 8'h07, 0, 2, -1);
    refill(20'h00002, 6'h02, 4'hF, 8'h09, 0, -1, 1);
    refill(20'hFFFFF, 6'h00, 4'hF, 8'h33, 0, -1, -1);

    @(negedge clk_i);
    miss_i = 1'b1;
    miss_tag_i = 20'h3C3C3;
    miss_idx_i = 6'h15;
    way_valid_bits_i = 4'hF;
    @(negedge clk_i);
    miss_i = 1'b0;
    mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i = 64'h0123_4567_89AB_CDEF;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b0;
    rr = 0;
    #1;
    all_zero("midrst");
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    mem_rsp_valid_i = 1'b0;
    chk("drop_idle_beat", ifill_data_o, '0);

    refill(20'h76543, 6'h2C, 4'hF, 8'h77, 0, -1, -1);

    repeat (3) @(negedge clk_i);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
